cmd_control: RTL
================

// Module: cmd_control
// PURPOSE
//  Command-path control stage, directly upstream of the CMD physical layer.
//  - Takes a command request (index + argument) from the host register side.
//  - Builds the 40-bit frame and runs the strobe/ack/idle handshake with the physical layer.
//  - Times out a missing response.
//  - Checks the received 48-bit response (start/transmission/index/CRC7/end bit).
//  - Reports completion and per-cause error flags to the host.
// PARAMETERS
//  TIMEOUT_CYCLES  64  sd_clock cycles strobe may stay high with no phy_complete before timeout
// PORTS
//  sd_clock          in   1   block clock
//  reset             in   1   asynchronous, active-low reset
//  new_command       in   1   host request pulse; sampled only in IDLE
//  cmd_index         in   6   command index
//  cmd_argument      in   32  command argument
//  no_response_req   in   1   command expects no response
//  phy_complete      in   1   physical layer finished (response captured or frame sent)
//  phy_response      in   48  response frame from physical layer, bit 47 = start bit
//  cmd_to_send       out  40  {1'b0, 1'b1, cmd_index, cmd_argument}, to physical layer
//  strobe_out        out  1   start/hold transaction at physical layer
//  ack_out           out  1   one-cycle acknowledge of phy_complete or timeout
//  idle_out          out  1   block idle
//  no_response_out   out  1   latched no_response_req, to physical layer
//  busy              out  1   transaction in progress (not IDLE)
//  command_complete  out  1   one-cycle pulse at end of every transaction
//  response_out      out  32  phy_response[39:8], held until next accepted command
//  timeout_error     out  1   status flag, held until next accepted command
//  index_error       out  1   status flag, held until next accepted command
//  crc_error         out  1   status flag, held until next accepted command
//  end_bit_error     out  1   status flag, held until next accepted command
// BEHAVIOUR
//  Reset (reset=0, async)
//  - State -> IDLE from any state, including mid-transaction.
//  - idle_out=1; all other outputs, counters and CRC = 0.
//  - The physical layer sees strobe_out drop in the same cycle.
//  States
//  - IDLE
//    - idle_out=1.
//    - new_command=1: latch index/arg/no_response_req; clear all four error flags and response_out; -> LOAD.
//    - new_command while busy is ignored, no error.
//  - LOAD (1 cycle)
//    - cmd_to_send and no_response_out valid; idle_out=0; -> WAIT.
//    - cmd_to_send is stable from LOAD until the next accepted command.
//  - WAIT
//    - strobe_out=1; 16-bit timer increments each cycle from 0.
//    - phy_complete=1:
//      - strobe_out=0 next cycle; ack_out=1 for exactly one cycle.
//      - Capture phy_response.
//      - -> DONE if no_response latched, else -> CHECK.
//    - Timer reaches TIMEOUT_CYCLES-1 without phy_complete:
//      - timeout_error=1; strobe_out=0; ack_out pulse; -> DONE.
//    - phy_complete on the same cycle as the timeout limit: complete wins, no timeout.
//  - CHECK (40 cycles)
//    - Serial CRC7, polynomial x^7+x^3+1, init 0, over captured bits 47..8, MSB first.
//    - Per bit: fb = crc[6]^bit; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
//    - After bit 8: crc_error = (crc != resp[7:1]).
//    - index_error = resp[47] | resp[46] | (resp[45:40] != latched index).
//    - end_bit_error = ~resp[0].
//    - response_out = resp[39:8]; -> DONE.
//  - DONE (1 cycle)
//    - command_complete=1; -> IDLE.
//    - busy=0 and new_command accepted from the following cycle.
//  Latency
//  - new_command -> strobe_out: 2 cycles.
//  - phy_complete -> command_complete: 2 cycles (no response) or 42 cycles (with response).
//  - Timeout path: command_complete 2 cycles after timer expiry.
// TESTING
//  1. Reset mid-WAIT (strobe_out=1): drop reset -> same cycle strobe_out=0, idle_out=1, busy=0, flags 0.
//  2. CMD0, arg 0, no_response_req=1; phy_complete after 10 cycles:
//     -> cmd_to_send=40'h40_0000_0000; one ack_out; command_complete; all flags 0.
//  3. CMD17, arg 0; phy_response = {8'h11, 32'h0000_0900, crc7_model, 1'b1}:
//     -> response_out=32'h0000_0900; no error flags; complete 42 cycles after phy_complete.
//  4. Same as 3 with bit 20 flipped -> crc_error=1.
//     Index field 6'h12 -> index_error=1.
//     Bit 0 = 0 -> end_bit_error=1.
//  5. Hold phy_complete=0 -> strobe_out drops after 64 WAIT cycles; timeout_error=1; ack_out pulse.
//     phy_complete on cycle 64 instead -> timeout_error=0.
//  6. new_command pulsed during WAIT and CHECK -> ignored, latched cmd_to_send unchanged.
//     Next new_command after DONE is accepted.

Source files
------------

// File: rtl/cmd_control.sv
// Command-path control: frames a host command, runs the strobe/ack handshake with the
// CMD physical layer, times out missing responses and checks the 48-bit response.
module cmd_control #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        new_command,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_argument,
    input  logic        no_response_req,
    input  logic        phy_complete,
    input  logic [47:0] phy_response,
    output logic [39:0] cmd_to_send,
    output logic        strobe_out,
    output logic        ack_out,
    output logic        idle_out,
    output logic        no_response_out,
    output logic        busy,
    output logic        command_complete,
    output logic [31:0] response_out,
    output logic        timeout_error,
    output logic        index_error,
    output logic        crc_error,
    output logic        end_bit_error
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [39:0] cmd_q, cmd_d;
    logic        nores_q, nores_d;
    logic [15:0] timer_q, timer_d;
    logic [47:0] resp_q, resp_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic [31:0] rsp_out_q, rsp_out_d;
    logic        tmo_q, tmo_d;
    logic        idx_err_q, idx_err_d;
    logic        crc_err_q, crc_err_d;
    logic        end_err_q, end_err_d;
    logic        ack_q, ack_d;
    logic        cmpl_q, cmpl_d;
    logic [6:0]  crc_next;
    logic        timer_exp;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign crc_next  = crc7_step(crc_q, shift_q[39]);
    assign timer_exp = (timer_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            nores_q   <= 1'b0;
            timer_q   <= '0;
            resp_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            rsp_out_q <= '0;
            tmo_q     <= 1'b0;
            idx_err_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            ack_q     <= 1'b0;
            cmpl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            nores_q   <= nores_d;
            timer_q   <= timer_d;
            resp_q    <= resp_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            rsp_out_q <= rsp_out_d;
            tmo_q     <= tmo_d;
            idx_err_q <= idx_err_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            ack_q     <= ack_d;
            cmpl_q    <= cmpl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        nores_d   = nores_q;
        timer_d   = timer_q;
        resp_d    = resp_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        rsp_out_d = rsp_out_q;
        tmo_d     = tmo_q;
        idx_err_d = idx_err_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        ack_d     = 1'b0;
        cmpl_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_command) begin
                    cmd_d     = {2'b01, cmd_index, cmd_argument};
                    nores_d   = no_response_req;
                    rsp_out_d = '0;
                    tmo_d     = 1'b0;
                    idx_err_d = 1'b0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the limit cycle takes priority over the timeout
                if (phy_complete) begin
                    ack_d   = 1'b1;
                    resp_d  = phy_response;
                    shift_d = phy_response[47:8];
                    crc_d   = '0;
                    cnt_d   = '0;
                    state_d = nores_q ? S_DONE : S_CHECK;
                end else if (timer_exp) begin
                    ack_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_CHECK: begin
                crc_d   = crc_next;
                shift_d = {shift_q[38:0], 1'b0};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd39) begin
                    crc_err_d = (crc_next != resp_q[7:1]);
                    idx_err_d = resp_q[47] | resp_q[46] | (resp_q[45:40] != cmd_q[37:32]);
                    end_err_d = ~resp_q[0];
                    rsp_out_d = resp_q[39:8];
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                cmpl_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_to_send      = cmd_q;
    assign strobe_out       = (state_q == S_WAIT);
    assign ack_out          = ack_q;
    assign idle_out         = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign no_response_out  = nores_q;
    assign command_complete = cmpl_q;
    assign response_out     = rsp_out_q;
    assign timeout_error    = tmo_q;
    assign index_error      = idx_err_q;
    assign crc_error        = crc_err_q;
    assign end_bit_error    = end_err_q;

endmodule
